// File: rtl/icache_nway_if.sv
// icache_nway_if
// Bundles the fetch-side request/response signals, the set-invalidate
// port, the AXI read-bridge request/return signals and the performance
// counters of the instruction cache into one interface.
//
// Parameters:
//   INDEX_W  - set index bits
//   OFFSET_W - byte offset bits (line = 2^OFFSET_W bytes)
//
// Modports:
//   slave  - seen by the cache (icache_nway)
//   master - seen by whatever drives the cache (fetch stage + bridge model)
//
// Signal summary:
//   valid/uncache/tag/index/offset  fetch request
//   addr_ok/data_ok/rdata           fetch handshake and returned word
//   inv_valid/inv_index/inv_ready   set invalidate
//   rd_req/rd_type/rd_addr/rd_rdy   bridge read request
//   ret_valid/ret_data              bridge single-beat return
//   hit_cnt/miss_cnt                cached hit/miss counters

interface icache_nway_if #(
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
);
    localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
    localparam int LINE_W = 8 << OFFSET_W;

    logic                valid;
    logic                uncache;
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic                addr_ok;
    logic                data_ok;
    logic [31:0]         rdata;

    logic                inv_valid;
    logic [INDEX_W-1:0]  inv_index;
    logic                inv_ready;

    logic                rd_req;
    logic                rd_type;
    logic [31:0]         rd_addr;
    logic                rd_rdy;
    logic                ret_valid;
    logic [LINE_W-1:0]   ret_data;

    logic [31:0]         hit_cnt;
    logic [31:0]         miss_cnt;

    modport slave (
        input  valid, uncache, tag, index, offset,
        input  inv_valid, inv_index,
        input  rd_rdy, ret_valid, ret_data,
        output addr_ok, data_ok, rdata, inv_ready,
        output rd_req, rd_type, rd_addr,
        output hit_cnt, miss_cnt
    );

    modport master (
        output valid, uncache, tag, index, offset,
        output inv_valid, inv_index,
        output rd_rdy, ret_valid, ret_data,
        input  addr_ok, data_ok, rdata, inv_ready,
        input  rd_req, rd_type, rd_addr,
        input  hit_cnt, miss_cnt
    );

endinterface

// File: rtl/icache_nway.sv
// icache_nway
// Parametrised set-associative read-only instruction cache sitting between
// the fetch stage and the AXI read bridge. Cached requests look up WAYS
// synchronous tag/data arrays one cycle after acceptance; hits stream back
// at one word per cycle, misses refill a whole line in a single beat into a
// victim chosen as the lowest invalid way or else the set's round-robin
// pointer. Uncached requests go straight to the bridge as single-word reads
// and never allocate. A set-invalidate port clears every way of one set
// while the cache is idle.
//
// Parameters:
//   WAYS     - associativity, power of two, 1..8
//   INDEX_W  - set index bits
//   OFFSET_W - byte offset bits (>= 2)
//
// Ports:
//   clk    - clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - icache_nway_if.slave (fetch, invalidate, bridge, counters)
//
// Configuration macro:
//   ICACHE_PERF_EN - when defined, hit_cnt/miss_cnt count cached lookup
//                    hits/misses; when undefined they are tied to 0 and no
//                    counter flops exist.

module icache_nway #(
    parameter int WAYS     = 2,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
) (
    input  logic          clk,
    input  logic          resetn,
    icache_nway_if.slave  bus
);

    localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
    localparam int LINE_W = 8 << OFFSET_W;
    localparam int SETS   = 1 << INDEX_W;
    localparam int WORDS  = LINE_W / 32;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_REFILL,
        S_UC_REQ,
        S_UC_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [TAG_W-1:0]    r_rbTag;
    logic [INDEX_W-1:0]  r_rbIndex;
    logic [OFFSET_W-1:0] r_rbOffset;
    logic                r_rbUncache;

    logic [SETS-1:0]     r_valid [WAYS];
    logic [WAY_W-1:0]    r_rrPtr [SETS];
    logic [WAY_W-1:0]    r_victim;

    logic                w_addrOk;
    logic                w_dataOk;
    logic [31:0]         w_rdata;
    logic                w_invReady;
    logic                w_fillEn;
    logic                w_lookupMiss;
    logic                w_anyHit;
    logic [WAYS-1:0]     w_hitVec;
    logic [WAYS-1:0][LINE_W-1:0] w_wayLine;
    logic [LINE_W-1:0]   w_hitLine;
    logic [OFFSET_W-1:0] w_wordSel;
    logic [WAY_W-1:0]    w_victimSel;
    logic                w_anyInvalid;
    logic [WAY_W-1:0]    w_rrNext;

    // Pick 32-bit word 'sel' out of a line; 'sel' is the offset with the
    // byte-within-word bits shifted away.
    function automatic logic [31:0] pickWord(input logic [LINE_W-1:0] line,
                                             input logic [OFFSET_W-1:0] sel);
        logic [31:0] word;
        word = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (sel == OFFSET_W'(k)) begin
                word = line[32*k +: 32];
            end
        end
        return word;
    endfunction

    assign w_wordSel = r_rbOffset >> 2;

    // Per-way storage. The arrays are read at acceptance time with the
    // incoming index so that tag and line are available in LOOKUP.
    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic [TAG_W-1:0]  r_tagMem  [SETS];
        logic [LINE_W-1:0] r_lineMem [SETS];
        logic [TAG_W-1:0]  r_tagRd;
        logic [LINE_W-1:0] r_lineRd;

        always_ff @(posedge clk) begin
            if (w_fillEn && (r_victim == WAY_W'(g))) begin
                r_tagMem[r_rbIndex]  <= r_rbTag;
                r_lineMem[r_rbIndex] <= bus.ret_data;
            end
            if (w_addrOk) begin
                r_tagRd  <= r_tagMem[bus.index];
                r_lineRd <= r_lineMem[bus.index];
            end
        end

        assign w_hitVec[g]  = r_valid[g][r_rbIndex] && (r_tagRd == r_rbTag);
        assign w_wayLine[g] = r_lineRd;
    end

    assign w_anyHit = |w_hitVec;

    // At most one way hits, so OR-ing the gated lines selects the hit line.
    always_comb begin
        w_hitLine = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_hitVec[w]) begin
                w_hitLine = w_hitLine | w_wayLine[w];
            end
        end
    end

    // Victim: scanning from the top down leaves the lowest invalid way
    // selected; with a full set the round-robin pointer decides.
    always_comb begin
        w_victimSel  = r_rrPtr[r_rbIndex];
        w_anyInvalid = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][r_rbIndex]) begin
                w_victimSel  = WAY_W'(w);
                w_anyInvalid = 1'b1;
            end
        end
    end

    assign w_rrNext = (r_rrPtr[r_rbIndex] == WAY_W'(WAYS - 1)) ? '0
                                                                : r_rrPtr[r_rbIndex] + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_nextState  = r_state;
        w_addrOk     = 1'b0;
        w_dataOk     = 1'b0;
        w_rdata      = '0;
        w_invReady   = 1'b0;
        w_fillEn     = 1'b0;
        w_lookupMiss = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.inv_valid) begin
                    w_invReady = 1'b1;
                end else if (bus.valid) begin
                    w_addrOk    = 1'b1;
                    w_nextState = bus.uncache ? S_UC_REQ : S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_anyHit) begin
                    w_dataOk = 1'b1;
                    w_rdata  = pickWord(w_hitLine, w_wordSel);
                    if (bus.valid && !bus.inv_valid) begin
                        w_addrOk    = 1'b1;
                        w_nextState = bus.uncache ? S_UC_REQ : S_LOOKUP;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end else begin
                    w_lookupMiss = 1'b1;
                    w_nextState  = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                if (bus.rd_rdy) begin
                    w_nextState = S_REFILL;
                end
            end
            S_REFILL: begin
                if (bus.ret_valid) begin
                    w_fillEn    = 1'b1;
                    w_dataOk    = 1'b1;
                    w_rdata     = pickWord(bus.ret_data, w_wordSel);
                    w_nextState = S_IDLE;
                end
            end
            S_UC_REQ: begin
                if (bus.rd_rdy) begin
                    w_nextState = S_UC_WAIT;
                end
            end
            S_UC_WAIT: begin
                if (bus.ret_valid) begin
                    w_dataOk    = 1'b1;
                    w_rdata     = bus.ret_data[31:0];
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Request buffer: captured on every accepted request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rbTag     <= '0;
            r_rbIndex   <= '0;
            r_rbOffset  <= '0;
            r_rbUncache <= 1'b0;
        end else if (w_addrOk) begin
            r_rbTag     <= bus.tag;
            r_rbIndex   <= bus.index;
            r_rbOffset  <= bus.offset;
            r_rbUncache <= bus.uncache;
        end
    end

    // Victim latch and round-robin update; the pointer only advances when
    // it was actually used to pick the victim.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_victim <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_rrPtr[s] <= '0;
            end
        end else if (w_lookupMiss) begin
            r_victim <= w_victimSel;
            if (!w_anyInvalid) begin
                r_rrPtr[r_rbIndex] <= w_rrNext;
            end
        end
    end

    // Valid bits. Invalidate only happens in IDLE and fill only in REFILL,
    // so the two never touch the array in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
            end
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (w_invReady) begin
                    r_valid[w][bus.inv_index] <= 1'b0;
                end
                if (w_fillEn && (r_victim == WAY_W'(w))) begin
                    r_valid[w][r_rbIndex] <= 1'b1;
                end
            end
        end
    end

    assign bus.addr_ok   = w_addrOk;
    assign bus.data_ok   = w_dataOk;
    assign bus.rdata     = w_rdata;
    assign bus.inv_ready = w_invReady;

    // Bridge request: asserted purely from state, address/type from the
    // request buffer.
    assign bus.rd_req  = (r_state == S_MISS_REQ) || (r_state == S_UC_REQ);
    assign bus.rd_type = !r_rbUncache;
    assign bus.rd_addr = r_rbUncache ? {r_rbTag, r_rbIndex, r_rbOffset}
                                     : {r_rbTag, r_rbIndex, {OFFSET_W{1'b0}}};

`ifdef ICACHE_PERF_EN
    logic        w_lookupHit;
    logic [31:0] r_hitCnt;
    logic [31:0] r_missCnt;

    assign w_lookupHit = (r_state == S_LOOKUP) && w_anyHit;

    // Counters wrap naturally at 32 bits; uncached traffic never reaches
    // LOOKUP and so is never counted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hitCnt  <= '0;
            r_missCnt <= '0;
        end else begin
            if (w_lookupHit) begin
                r_hitCnt <= r_hitCnt + 32'd1;
            end
            if (w_lookupMiss) begin
                r_missCnt <= r_missCnt + 32'd1;
            end
        end
    end

    assign bus.hit_cnt  = r_hitCnt;
    assign bus.miss_cnt = r_missCnt;
`else
    assign bus.hit_cnt  = '0;
    assign bus.miss_cnt = '0;
`endif

endmodule

// File: doc/icache_nway.md
# icache_nway

Parametrised set-associative, read-only instruction cache between the fetch stage and the AXI read bridge. It generalises the existing 2-way/256-set/16-byte instruction cache to WAYS ways, 2^INDEX_W sets and 2^OFFSET_W-byte lines. It keeps the split cached/uncached request protocol, pipelined back-to-back hits and single-beat line refill. It adds registered uncached requests, per-set round-robin replacement and a set-invalidate port for the CACHE instruction.

## Interface
- WAYS, 2, associativity; power of two, 1..8
- INDEX_W, 8, set index bits
- OFFSET_W, 4, byte offset bits; line = 2^OFFSET_W bytes, minimum 4
- TAG_W, 32-INDEX_W-OFFSET_W, derived tag width
- LINE_W, 8<<OFFSET_W, derived refill data width
- clk  in  1  clock; all logic on the rising edge
- resetn  in  1  reset; asynchronous, active-low
- valid  in  1  fetch request valid
- uncache  in  1  request is uncached
- tag  in  TAG_W  request tag
- index  in  INDEX_W  request set index
- offset  in  OFFSET_W  byte offset; bits [1:0] are ignored
- addr_ok  out  1  request accepted this cycle (valid && addr_ok)
- data_ok  out  1  rdata valid this cycle
- rdata  out  32  returned instruction word
- inv_valid  in  1  invalidate all ways of set inv_index
- inv_index  in  INDEX_W  set to invalidate
- inv_ready  out  1  invalidate performed this cycle
- rd_req  out  1  AXI read request
- rd_type  out  1  1 = full line, 0 = single word
- rd_addr  out  32  read address
- rd_rdy  in  1  bridge accepts rd_req
- ret_valid  in  1  return data valid; single beat
- ret_data  in  LINE_W  returned line; word k at [32k+31:32k]; uncached word at [31:0]
- hit_cnt  out  32  cached hit count
- miss_cnt  out  32  cached miss count

## Operation
- Storage: per way, a tag array (TAG_W bits) and a data array (LINE_W bits) with synchronous read, producing data one cycle after the address is presented.
- Valid bits are flops, WAYS×2^INDEX_W, cleared by reset. The per-set round-robin pointer is clog2(WAYS) bits wide and reset to 0.
- Request buffer: tag, index, offset and the uncache bit are captured on every accepted request.
- States: IDLE, LOOKUP, MISS_REQ, REFILL, UC_REQ, UC_WAIT.
- addr_ok = valid && !inv_valid && (state==IDLE || (state==LOOKUP && hit)).
- IDLE:
  - inv_valid has priority over valid. It clears all valid bits of inv_index, asserts inv_ready for 1 cycle and stays in IDLE.
  - An accepted cached request goes to LOOKUP.
  - An accepted uncached request goes to UC_REQ.
- LOOKUP:
  - way w hits when valid[w][rb_index] is set and tag_w == rb_tag. The WAYS>1 case never sets more than one hit.
  - On a hit: data_ok=1 and rdata = word rb_offset[OFFSET_W-1:2] of the hit way. Next state is LOOKUP (new cached request accepted), UC_REQ (new uncached request) or IDLE (nothing accepted).
  - On a miss: choose the victim. The lowest-numbered invalid way wins; otherwise the set's round-robin pointer, which then increments modulo WAYS. Next state is MISS_REQ.
- MISS_REQ: rd_req=1, rd_type=1, rd_addr={rb_tag, rb_index, 0}. Holds until rd_rdy, then goes to REFILL.
- REFILL: on ret_valid:
  - write ret_data and the tag into the victim way and set its valid bit;
  - data_ok=1 with the requested word taken from ret_data;
  - go to IDLE.
- UC_REQ: rd_req=1, rd_type=0, rd_addr={rb_tag, rb_index, rb_offset}. Goes to UC_WAIT on rd_rdy.
- UC_WAIT: on ret_valid, data_ok=1 and rdata=ret_data[31:0], then IDLE. Uncached requests never allocate a line.
- rd_req is driven only from registered state; rd_addr and rd_type come from the request buffer.
- inv_valid outside IDLE is held pending: inv_ready=0 and no effect until IDLE.

## Timing
- Reset values:
  - state IDLE;
  - data_ok, inv_ready and rd_req 0;
  - rdata 0;
  - hit_cnt and miss_cnt 0.
- addr_ok is combinational from valid and inv_valid.
- Hit latency: data_ok exactly 1 cycle after acceptance. Back-to-back hits sustain 1 word/cycle.
- Miss latency: 1 (LOOKUP) + cycles to rd_rdy + cycles to ret_valid. data_ok fires in the ret_valid cycle. addr_ok=0 from the miss until back in IDLE.
- rd_req is asserted no earlier than the cycle after the miss is detected.
- Reset asserted mid-refill: the FSM returns to IDLE immediately and all valid bits clear. A later stale ret_valid in IDLE is ignored.
- Invalidate and refill of the same set never coincide, because invalidates execute only in IDLE.

## Configuration
- ICACHE_PERF_EN defined: hit_cnt increments on each LOOKUP hit and miss_cnt on each LOOKUP miss. Both are 32-bit, wrap from 0xFFFFFFFF to 0 and are never incremented by uncached accesses.
- ICACHE_PERF_EN undefined: hit_cnt and miss_cnt are constant 0 and no counter flops are built.

## Test plan
- Cold miss: resetn 0→1, cached fetch 0x1FC00004 with WAYS=2 → rd_req with rd_type=1, rd_addr=0x1FC00000. Return line {W3,W2,W1,W0} → data_ok with rdata=W1; miss_cnt=1.
- Back-to-back hits: after the fill, fetch 0x1FC00000, 0x1FC00008 and 0x1FC0000C on consecutive cycles → addr_ok=1 each cycle, data_ok on 3 consecutive cycles returning W0, W2, W3; hit_cnt=3.
- Replacement with WAYS=4: fill 5 distinct tags into set 0 → the first four fill ways 0-3; the fifth evicts way 0. Refetching the first tag misses again.
- Uncached: fetch 0xBFC00010 with uncache=1 → rd_type=0, rd_addr=0xBFC00010; ret_data[31:0]=0x24080001 → rdata=0x24080001. A repeat also misses, and hit_cnt/miss_cnt are unchanged.
- Invalidate: a valid line at index 5, then inv_valid with inv_index=5 in IDLE → inv_ready for 1 cycle with addr_ok=0. The next fetch to that line misses.
- Reset mid-refill: assert resetn=0 in REFILL before ret_valid → rd_req=0 and state IDLE. A subsequent ret_valid produces no data_ok, and a refetch misses.
